// File: rtl/fp_wb_arbiter_pkg.sv
// Shared types and constants for the FP intermediate writeback arbiter:
// the payload handed from the FP sub-units to normalization/rounding.
package fp_wb_arbiter_pkg;

  localparam int FP_WB_UNITS_DEFAULT = 4;

  localparam int FP_WB_MISC_IDX = 0;
  localparam int FP_WB_ADD_IDX  = 1;
  localparam int FP_WB_MUL_IDX  = 2;
  localparam int FP_WB_DIV_IDX  = 3;

  typedef struct packed {
    logic [63:0] rd;
    logic [2:0]  grs;
    logic [6:0]  clz;
    logic        hidden;
    logic        carry;
    logic        safe;
    logic        expo_overflow;
    logic        subnormal;
    logic        right_shift;
    logic [6:0]  right_shift_amt;
    logic        ignore_max_expo;
    logic        d2s;
    logic [2:0]  rm;
    logic [4:0]  fflags;
    logic [3:0]  id;
  } fp_wb_payload_t;

endpackage

// File: rtl/fp_wb_arbiter_rr_sel.sv
// Circular first-one finder: returns the first set req bit at or after
// rr_ptr_i (wrapping NUM_UNITS-1 -> 0) as a one-hot grant plus its index.
module rr_priority_sel #(
  parameter int NUM_UNITS = 4,
  parameter int IDX_W     = $clog2(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0] req_i,
  input  logic [IDX_W-1:0]     rr_ptr_i,
  output logic [NUM_UNITS-1:0] grant_o,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_o
);

  always_comb begin
    int j;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      j = (int'(rr_ptr_i) + k) % NUM_UNITS;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IDX_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// Arbitrates the single FP intermediate writeback path between the FP
// sub-units and registers the granted unit's payload for post-processing.
module fp_wb_arbiter
  import fp_wb_arbiter_pkg::*;
#(
  parameter int                   NUM_UNITS       = FP_WB_UNITS_DEFAULT,
  parameter logic [NUM_UNITS-1:0] FIXED_PRIO_MASK = '0,
  localparam int                  IDX_W           = $clog2(NUM_UNITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_UNITS-1:0] unit_req,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  fp_wb_payload_t       unit_wb [NUM_UNITS],
  output logic [NUM_UNITS-1:0] unit_ack,
  output logic                 out_valid,
  output fp_wb_payload_t       out_wb,
  output logic [IDX_W-1:0]     out_src,
  input  logic                 out_ready
);

  logic                 out_valid_q;
  fp_wb_payload_t       out_wb_q;
  logic [IDX_W-1:0]     out_src_q;
  logic [IDX_W-1:0]     rr_ptr_q;

  logic [NUM_UNITS-1:0] fixed_req;
  logic [NUM_UNITS-1:0] fix_oh;
  logic [IDX_W-1:0]     fix_idx;
  logic                 fix_hit;

  logic [NUM_UNITS-1:0] rr_oh;
  logic [IDX_W-1:0]     rr_idx;
  logic                 rr_any;

  logic [IDX_W-1:0]     sel_idx;
  logic                 can_accept;
  logic                 xfer;

  assign fixed_req  = unit_req & FIXED_PRIO_MASK;
  assign can_accept = ~out_valid_q | out_ready;

  // Non-stallable units: lowest index wins, independent of rr_ptr.
  always_comb begin
    fix_oh  = '0;
    fix_idx = '0;
    fix_hit = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!fix_hit && fixed_req[i]) begin
        fix_hit   = 1'b1;
        fix_oh[i] = 1'b1;
        fix_idx   = IDX_W'(i);
      end
    end
  end

  rr_priority_sel #(
    .NUM_UNITS (NUM_UNITS),
    .IDX_W     (IDX_W)
  ) u_rr_sel (
    .req_i    (unit_req),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (rr_oh),
    .idx_o    (rr_idx),
    .any_o    (rr_any)
  );

  assign sel_idx = fix_hit ? fix_idx : rr_idx;

  always_comb begin
    unit_ack = '0;
    if (rst_n && can_accept) begin
      unit_ack = fix_hit ? fix_oh : rr_oh;
    end
  end

  // Done is only legal on the acked unit, so sel_idx names the source.
  assign xfer = |(unit_done & unit_ack);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_wb_q    <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_wb_q    <= unit_wb[sel_idx];
        out_src_q   <= sel_idx;
        if (!fix_hit) begin
          rr_ptr_q <= (sel_idx == IDX_W'(NUM_UNITS - 1)) ? '0 : sel_idx + 1'b1;
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_wb    = out_wb_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed bench for fp_wb_arbiter: one instance with pure round-robin and
// one with unit 2 non-stallable, sharing clock, reset, payloads and out_ready.
module tb_fp_wb_arbiter;
  import fp_wb_arbiter_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           out_ready;
  fp_wb_payload_t wb [4];

  logic [3:0]     req0, done0, ack0;
  logic           valid0;
  fp_wb_payload_t owb0;
  logic [1:0]     src0;

  logic [3:0]     req1, done1, ack1;
  logic           valid1;
  fp_wb_payload_t owb1;
  logic [1:0]     src1;

  int checks = 0;
  int errors = 0;

  fp_wb_arbiter #(.NUM_UNITS(4), .FIXED_PRIO_MASK(4'b0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .unit_req(req0), .unit_done(done0),
    .unit_wb(wb), .unit_ack(ack0), .out_valid(valid0), .out_wb(owb0),
    .out_src(src0), .out_ready(out_ready)
  );

  fp_wb_arbiter #(.NUM_UNITS(4), .FIXED_PRIO_MASK(4'b0100)) dut1 (
    .clk(clk), .rst_n(rst_n), .unit_req(req1), .unit_done(done1),
    .unit_wb(wb), .unit_ack(ack1), .out_valid(valid1), .out_wb(owb1),
    .out_src(src1), .out_ready(out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unit-side protocol: done only with ack, at most one done.
  always @(posedge clk) begin
    if (rst_n) begin
      chk("proto_done_ack0", 64'((done0 & ~ack0) == 4'b0), 64'd1);
      chk("proto_onehot0",   64'($onehot0(done0)), 64'd1);
      chk("proto_done_ack1", 64'((done1 & ~ack1) == 4'b0), 64'd1);
      chk("proto_onehot1",   64'($onehot0(done1)), 64'd1);
    end
  end

  initial begin
    logic [3:0] exp_oh;
    int e;
    rst_n = 1'b0; out_ready = 1'b1;
    req0 = '0; done0 = '0; req1 = '0; done1 = '0;
    for (int i = 0; i < 4; i++) begin
      wb[i]    = '0;
      wb[i].id = 4'(i + 4);
      wb[i].rd = 64'hA000 + 64'(i);
    end
    tick(); tick();

    // reset state
    chk("rst_valid0", 64'(valid0), 64'd0);
    chk("rst_src0",   64'(src0), 64'd0);
    chk("rst_wb0",    64'(owb0.rd), 64'd0);
    chk("rst_ptr0",   64'(dut0.rr_ptr_q), 64'd0);
    chk("rst_ack0",   64'(ack0), 64'd0);
    chk("rst_valid1", 64'(valid1), 64'd0);
    rst_n = 1'b1;
    #1;

    // single misc request
    wb[0].id = 4'd3;
    req0 = 4'b0001; done0 = 4'b0001;
    #1 chk("single_ack", 64'(ack0), 64'b0001);
    tick();
    chk("single_valid", 64'(valid0), 64'd1);
    chk("single_src",   64'(src0), 64'd0);
    chk("single_id",    64'(owb0.id), 64'd3);
    chk("single_ptr",   64'(dut0.rr_ptr_q), 64'd1);
    req0 = '0; done0 = '0;
    wb[0].id = 4'd4;
    tick();
    chk("single_drain", 64'(valid0), 64'd0);

    // round-robin rotation from rr_ptr=1: 1,2,3,0,1 back to back
    req0 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = (1 + k) % 4;
      exp_oh = 4'b0001 << e;
      done0 = exp_oh;
      #1 chk("rr_ack", 64'(ack0), 64'(exp_oh));
      tick();
      chk("rr_valid", 64'(valid0), 64'd1);
      chk("rr_src",   64'(src0), 64'(e));
      chk("rr_id",    64'(owb0.id), 64'(e + 4));
    end
    chk("rr_ptr_end", 64'(dut0.rr_ptr_q), 64'd2);
    req0 = '0; done0 = '0;

    // backpressure: register holds unit 1 result (id 5)
    out_ready = 1'b0; req0 = 4'b0010;
    #1 chk("bp_ack_blocked", 64'(ack0), 64'd0);
    tick();
    chk("bp_hold_valid", 64'(valid0), 64'd1);
    chk("bp_hold_src",   64'(src0), 64'd1);
    chk("bp_hold_id",    64'(owb0.id), 64'd5);
    wb[1].id = 4'd9;
    out_ready = 1'b1; done0 = 4'b0010;
    #1 chk("bp_ack_release", 64'(ack0), 64'b0010);
    tick();
    chk("bp_new_valid", 64'(valid0), 64'd1);
    chk("bp_new_id",    64'(owb0.id), 64'd9);
    chk("bp_ptr",       64'(dut0.rr_ptr_q), 64'd2);

    // ack without done: no capture, register drains, pointer stays
    done0 = '0; req0 = 4'b0010;
    #1 chk("nodone_ack", 64'(ack0), 64'b0010);
    tick();
    chk("nodone_valid", 64'(valid0), 64'd0);
    chk("nodone_ptr",   64'(dut0.rr_ptr_q), 64'd2);

    // reset mid-stream
    req0 = 4'b1111; done0 = 4'b0100;
    #1 chk("ms_ack", 64'(ack0), 64'b0100);
    tick();
    chk("ms_valid", 64'(valid0), 64'd1);
    chk("ms_ptr",   64'(dut0.rr_ptr_q), 64'd3);
    done0 = '0; rst_n = 1'b0;
    #1 chk("ms_ack_in_reset", 64'(ack0), 64'd0);
    tick();
    chk("ms_rst_valid", 64'(valid0), 64'd0);
    chk("ms_rst_ptr",   64'(dut0.rr_ptr_q), 64'd0);
    chk("ms_rst_src",   64'(src0), 64'd0);
    rst_n = 1'b1;
    #1 chk("ms_first_grant", 64'(ack0), 64'b0001);
    req0 = '0;

    // fixed priority on dut1 (unit 2 non-stallable), rr_ptr=0 after reset
    req1 = 4'b0111; done1 = 4'b0100;
    #1 chk("fp_ack_fixed", 64'(ack1), 64'b0100);
    tick();
    chk("fp_src",   64'(src1), 64'd2);
    chk("fp_id",    64'(owb1.id), 64'd6);
    chk("fp_ptr",   64'(dut1.rr_ptr_q), 64'd0);
    req1 = 4'b0011; done1 = 4'b0001;
    #1 chk("fp_ack_rr", 64'(ack1), 64'b0001);
    tick();
    chk("fp_rr_src", 64'(src1), 64'd0);
    chk("fp_rr_ptr", 64'(dut1.rr_ptr_q), 64'd1);
    req1 = 4'b0110; done1 = 4'b0100;
    #1 chk("fp_beats_rr", 64'(ack1), 64'b0100);
    tick();
    chk("fp_ptr_kept", 64'(dut1.rr_ptr_q), 64'd1);
    req1 = '0; done1 = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
